// File: rtl/burst_qualifier.sv
// Front-end burst qualifier: synchronises the raw carrier input, counts
// carrier edges and emits one det_pulse per valid burst, with runt rejection.
module burst_qualifier #(
    parameter int SYNC_STAGES    = 2,
    parameter int MIN_EDGES      = 4,
    parameter int GAP_CYCLES     = 15,
    parameter int HOLDOFF_CYCLES = 248,
    parameter int LEN_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    output logic             det_pulse,
    output logic             busy,
    output logic [7:0]       reject_cnt,
    output logic [LEN_W-1:0] burst_edges
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    localparam logic [GW-1:0]    GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);
    localparam logic [LEN_W-1:0] MIN_LAST  = LEN_W'(MIN_EDGES - 1);
    localparam logic [LEN_W-1:0] EDGE_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        ACTIVE,
        HOLDOFF
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   rise_q;

    logic [LEN_W-1:0] edge_cnt, edge_n;
    logic [GW-1:0]    gap_cnt, gap_n;
    logic [HW-1:0]    hold_cnt, hold_n;

    logic fire, fire_q;
    logic reject;
    logic capture;

    logic sync_out;
    assign sync_out = sync[SYNC_STAGES-1];

    // Synchroniser chain, edge history and registered rising-edge strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            hist   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], in};
            hist   <= sync_out;
            rise_q <= sync_out & ~hist;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            edge_cnt <= '0;
            gap_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            edge_cnt <= edge_n;
            gap_cnt  <= gap_n;
            hold_cnt <= hold_n;
        end
    end

    // Next-state logic; a qualifying rise takes priority over gap expiry
    always_comb begin
        state_n = state;
        edge_n  = edge_cnt;
        gap_n   = gap_cnt;
        hold_n  = hold_cnt;
        fire    = 1'b0;
        reject  = 1'b0;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise_q) begin
                    edge_n = LEN_W'(1);
                    gap_n  = '0;
                    if (MIN_EDGES == 1) begin
                        state_n = ACTIVE;
                        fire    = 1'b1;
                    end else begin
                        state_n = COUNT;
                    end
                end
            end
            COUNT: begin
                if (rise_q) begin
                    edge_n = edge_cnt + 1'b1;
                    gap_n  = '0;
                    if (edge_cnt == MIN_LAST) begin
                        state_n = ACTIVE;
                        fire    = 1'b1;
                    end
                end else if (gap_cnt == GAP_LAST) begin
                    state_n = IDLE;
                    gap_n   = '0;
                    reject  = 1'b1;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            ACTIVE: begin
                if (rise_q) begin
                    gap_n = '0;
                    if (edge_cnt != EDGE_MAX) begin
                        edge_n = edge_cnt + 1'b1;
                    end
                end else if (gap_cnt == GAP_LAST) begin
                    state_n = HOLDOFF;
                    gap_n   = '0;
                    hold_n  = '0;
                    capture = 1'b1;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            HOLDOFF: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_n = IDLE;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Registered outputs: delayed detect pulse, busy flag and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_q      <= 1'b0;
            det_pulse   <= 1'b0;
            busy        <= 1'b0;
            reject_cnt  <= '0;
            burst_edges <= '0;
        end else begin
            fire_q    <= fire;
            det_pulse <= fire_q;
            busy      <= (state_n != IDLE);
            if (reject && reject_cnt != 8'hFF) begin
                reject_cnt <= reject_cnt + 8'd1;
            end
            if (capture) begin
                burst_edges <= edge_cnt;
            end
        end
    end

endmodule
